// File: rtl/uart_rx_cmd_ctrl.sv
// UART command controller: decodes RX bytes into register-file writes/reads and ALU
// operations, and pushes read/ALU results back out through the TX FIFO.
module uart_rx_cmd_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [DATA_WIDTH-1:0]     i_rx_data,
   input  logic                      i_rx_data_valid,
   output logic [ADDR_WIDTH-1:0]     o_rf_addr,
   output logic                      o_rf_wr_en,
   output logic [DATA_WIDTH-1:0]     o_rf_wr_data,
   output logic                      o_rf_rd_en,
   input  logic [DATA_WIDTH-1:0]     i_rf_rd_data,
   input  logic                      i_rf_rd_valid,
   output logic                      o_alu_en,
   output logic [3:0]                o_alu_fun,
   output logic                      o_clk_gate_en,
   input  logic [2*DATA_WIDTH-1:0]   i_alu_out,
   input  logic                      i_alu_valid,
   output logic [DATA_WIDTH-1:0]     o_tx_data,
   output logic                      o_tx_valid,
   input  logic                      i_tx_full,
   output logic                      o_cmd_error
);

   localparam logic [DATA_WIDTH-1:0] CMD_WR   = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD   = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU  = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_FUN  = DATA_WIDTH'(8'hDD);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B,
      ALU_FUN, ALU_WAIT, TX_LO, TX_HI
   } state_t;

   state_t                    state, state_next;
   logic                      dv_q;
   logic                      rx_block_q;
   logic                      accept;
   logic [ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_next;
   logic [2*DATA_WIDTH-1:0]   result_q, result_next;
   logic                      two_byte_q, two_byte_next;
   logic [ADDR_WIDTH-1:0]     rf_addr_next;
   logic                      rf_wr_en_next;
   logic [DATA_WIDTH-1:0]     rf_wr_data_next;
   logic                      rf_rd_en_next;
   logic                      alu_en_next;
   logic [3:0]                alu_fun_next;
   logic                      clk_gate_en_next;
   logic [DATA_WIDTH-1:0]     tx_data_next;
   logic                      tx_valid_next;
   logic                      cmd_error_next;

   // rx_block_q keeps a valid level that straddles reset from being taken as a new byte
   assign accept = i_rx_data_valid & ~dv_q & ~rx_block_q;

   // Next-state and next-output decode
   always_comb begin
      state_next      = state;
      wr_addr_next    = wr_addr_q;
      result_next     = result_q;
      two_byte_next   = two_byte_q;
      rf_addr_next    = o_rf_addr;
      rf_wr_en_next   = 1'b0;
      rf_wr_data_next = o_rf_wr_data;
      rf_rd_en_next   = 1'b0;
      alu_en_next     = 1'b0;
      alu_fun_next    = o_alu_fun;
      tx_data_next    = o_tx_data;
      tx_valid_next   = 1'b0;
      cmd_error_next  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               case (i_rx_data)
                  CMD_WR:  state_next = WR_ADDR;
                  CMD_RD:  state_next = RD_ADDR;
                  CMD_ALU: state_next = ALU_A;
                  CMD_FUN: state_next = ALU_FUN;
                  default: cmd_error_next = 1'b1;
               endcase
            end else begin
               state_next = IDLE;
            end
         end
         WR_ADDR: begin
            if (accept) begin
               wr_addr_next = i_rx_data[ADDR_WIDTH-1:0];
               state_next   = WR_DATA;
            end else begin
               state_next = WR_ADDR;
            end
         end
         WR_DATA: begin
            if (accept) begin
               rf_wr_en_next   = 1'b1;
               rf_addr_next    = wr_addr_q;
               rf_wr_data_next = i_rx_data;
               state_next      = IDLE;
            end else begin
               state_next = WR_DATA;
            end
         end
         RD_ADDR: begin
            if (accept) begin
               rf_rd_en_next = 1'b1;
               rf_addr_next  = i_rx_data[ADDR_WIDTH-1:0];
               state_next    = RD_WAIT;
            end else begin
               state_next = RD_ADDR;
            end
         end
         RD_WAIT: begin
            cmd_error_next = accept;
            if (i_rf_rd_valid) begin
               result_next   = {{DATA_WIDTH{1'b0}}, i_rf_rd_data};
               two_byte_next = 1'b0;
               state_next    = TX_LO;
            end else begin
               state_next = RD_WAIT;
            end
         end
         ALU_A, ALU_B: begin
            if (accept) begin
               rf_wr_en_next   = 1'b1;
               rf_addr_next    = (state == ALU_A) ? {ADDR_WIDTH{1'b0}} : ADDR_ONE;
               rf_wr_data_next = i_rx_data;
               state_next      = (state == ALU_A) ? ALU_B : ALU_FUN;
            end else begin
               state_next = state;
            end
         end
         ALU_FUN: begin
            if (accept) begin
               alu_fun_next = i_rx_data[3:0];
               alu_en_next  = 1'b1;
               state_next   = ALU_WAIT;
            end else begin
               state_next = ALU_FUN;
            end
         end
         ALU_WAIT: begin
            cmd_error_next = accept;
            if (i_alu_valid) begin
               result_next   = i_alu_out;
               two_byte_next = 1'b1;
               state_next    = TX_LO;
            end else begin
               state_next = ALU_WAIT;
            end
         end
         TX_LO, TX_HI: begin
            cmd_error_next = accept;
            if (!i_tx_full) begin
               tx_valid_next = 1'b1;
               tx_data_next  = (state == TX_LO) ? result_q[DATA_WIDTH-1:0]
                                                : result_q[2*DATA_WIDTH-1:DATA_WIDTH];
               state_next    = (state == TX_LO && two_byte_q) ? TX_HI : IDLE;
            end else begin
               state_next = state;
            end
         end
         default: state_next = IDLE;
      endcase
      // Derived from the next state so the registered enable tracks the current state
      clk_gate_en_next = (state_next == ALU_FUN) || (state_next == ALU_WAIT);
   end

   // State, captured data and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= IDLE;
         dv_q          <= 1'b0;
         rx_block_q    <= 1'b1;
         wr_addr_q     <= {ADDR_WIDTH{1'b0}};
         result_q      <= {(2*DATA_WIDTH){1'b0}};
         two_byte_q    <= 1'b0;
         o_rf_addr     <= {ADDR_WIDTH{1'b0}};
         o_rf_wr_en    <= 1'b0;
         o_rf_wr_data  <= {DATA_WIDTH{1'b0}};
         o_rf_rd_en    <= 1'b0;
         o_alu_en      <= 1'b0;
         o_alu_fun     <= 4'h0;
         o_clk_gate_en <= 1'b0;
         o_tx_data     <= {DATA_WIDTH{1'b0}};
         o_tx_valid    <= 1'b0;
         o_cmd_error   <= 1'b0;
      end else begin
         state         <= state_next;
         dv_q          <= i_rx_data_valid;
         rx_block_q    <= rx_block_q & i_rx_data_valid;
         wr_addr_q     <= wr_addr_next;
         result_q      <= result_next;
         two_byte_q    <= two_byte_next;
         o_rf_addr     <= rf_addr_next;
         o_rf_wr_en    <= rf_wr_en_next;
         o_rf_wr_data  <= rf_wr_data_next;
         o_rf_rd_en    <= rf_rd_en_next;
         o_alu_en      <= alu_en_next;
         o_alu_fun     <= alu_fun_next;
         o_clk_gate_en <= clk_gate_en_next;
         o_tx_data     <= tx_data_next;
         o_tx_valid    <= tx_valid_next;
         o_cmd_error   <= cmd_error_next;
      end
   end

endmodule

// File: doc/uart_rx_cmd_ctrl.md
UART_RX_CMD_CTRL -- requirements
Module: uart_rx_cmd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, UART byte and register-file data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register-file address width.
REQ-003 SHALL have port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have ports i_rx_data (input, DATA_WIDTH) and i_rx_data_valid (input, 1): byte from UART RX; valid is a level that may stay high for several cycles per byte.
REQ-006 SHALL have ports o_rf_addr (output, ADDR_WIDTH), o_rf_wr_en (output, 1), o_rf_wr_data (output, DATA_WIDTH) and o_rf_rd_en (output, 1): register-file access.
REQ-007 SHALL have ports i_rf_rd_data (input, DATA_WIDTH) and i_rf_rd_valid (input, 1): register-file read return.
REQ-008 SHALL have ports o_alu_en (output, 1), o_alu_fun (output, 4) and o_clk_gate_en (output, 1): ALU control and ALU clock-gate enable.
REQ-009 SHALL have ports i_alu_out (input, 2*DATA_WIDTH) and i_alu_valid (input, 1): ALU result.
REQ-010 SHALL have ports o_tx_data (output, DATA_WIDTH), o_tx_valid (output, 1) and i_tx_full (input, 1): byte push into the TX FIFO.
REQ-011 SHALL have port o_cmd_error, output, 1: one-cycle pulse for an unknown or dropped byte.

Function
REQ-012 SHALL register i_rx_data_valid into dv_q and accept a byte only when i_rx_data_valid=1 and dv_q=0, so each valid burst yields exactly one byte.
REQ-013 SHALL register all outputs; a pulse caused by an accepted byte asserts in the cycle after the accepting edge.
REQ-014 SHALL implement states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI.
REQ-015 SHALL decode bytes in IDLE as follows: 0xAA goes to WR_ADDR, 0xBB to RD_ADDR, 0xCC to ALU_A, 0xDD to ALU_FUN; any other byte stays in IDLE and pulses o_cmd_error.
REQ-016 SHALL, in WR_ADDR, latch byte[ADDR_WIDTH-1:0] as the address and go to WR_DATA; in WR_DATA, pulse o_rf_wr_en for one cycle with the latched address and the byte, then go to IDLE.
REQ-017 SHALL, in RD_ADDR, pulse o_rf_rd_en for one cycle with o_rf_addr=byte[ADDR_WIDTH-1:0] and go to RD_WAIT; in RD_WAIT, wait with no timeout for i_rf_rd_valid, capture i_rf_rd_data and go to TX_LO as a single-byte response.
REQ-018 SHALL, in ALU_A, write the byte to address 0 (one-cycle o_rf_wr_en) and go to ALU_B; in ALU_B, write the byte to address 1 and go to ALU_FUN.
REQ-019 SHALL hold o_clk_gate_en=1 throughout ALU_FUN and ALU_WAIT, and 0 in all other states.
REQ-020 SHALL, in ALU_FUN, set o_alu_fun=byte[3:0], pulse o_alu_en for one cycle and go to ALU_WAIT; in ALU_WAIT, capture i_alu_out on i_alu_valid and go to TX_LO as a two-byte response.
REQ-021 SHALL, in TX_LO/TX_HI, present the low byte and then the high byte on o_tx_data, with a one-cycle o_tx_valid pulse per byte only in a cycle where i_tx_full=0; while i_tx_full=1, o_tx_valid SHALL be 0 and the state SHALL hold.
REQ-022 SHALL return a single-byte response (read) to IDLE after TX_LO; a two-byte response (ALU) SHALL go through TX_HI, then IDLE.
REQ-023 SHALL drop any byte accepted in RD_WAIT, ALU_WAIT, TX_LO or TX_HI, pulse o_cmd_error and leave the state unchanged.
REQ-024 SHALL ignore i_rf_rd_valid and i_alu_valid outside RD_WAIT and ALU_WAIT respectively.
REQ-025 SHALL allow a new command to be accepted in the first IDLE cycle after a transaction completes.

Reset
REQ-026 SHALL, while i_rst=1 at a clock edge, set the state to IDLE, dv_q=0, every output to 0 (including o_rf_addr, o_alu_fun and o_tx_data) and clear captured data.
REQ-027 SHALL, on reset mid-transaction, discard the pending transaction with no write, ALU or TX pulse; a byte whose valid is still high after reset releases SHALL NOT be accepted until valid falls and rises again.

Verification
REQ-028 SHALL cover write: bytes AA, 05, 3C -> exactly one o_rf_wr_en pulse with addr 5 and data 0x3C, and no o_tx_valid.
REQ-029 SHALL cover read: bytes BB, 07, with the RF returning 0x5A two cycles after o_rf_rd_en -> one o_rf_rd_en pulse at addr 7, then one o_tx_valid pulse with data 0x5A.
REQ-030 SHALL cover ALU: bytes CC, 10, 20, 01 with i_alu_out=0x0030, and i_tx_full high for 3 cycles after the first push -> writes addr0=0x10 and addr1=0x20, o_alu_en with fun=1, TX pushes 0x30 then 0x00 with the second push delayed by 3 cycles, and o_clk_gate_en=0 afterwards.
REQ-031 SHALL cover errors: byte 0x55 in IDLE -> one o_cmd_error pulse; then DD, 03 -> o_alu_en with fun=3; a byte sent during ALU_WAIT -> o_cmd_error pulse and state unchanged.
REQ-032 SHALL cover burst: i_rx_data_valid held high for 8 cycles with byte AA -> only one byte accepted, and the state goes to WR_ADDR.
REQ-033 SHALL cover reset: i_rst asserted in ALU_WAIT, followed by i_alu_valid -> all outputs 0, no TX push, and the next AA command processed normally.
